wr_ctrl: RTL and testbench

- Avalon-MM burst write master; the write-side counterpart of the packet read controller.
- Drains 32-bit words from a show-ahead FIFO and writes them to the host memory window [dst_begin, dst_end) as bursts of at most MAX_BURST words.
- Pulses wr_ctrl_rdy once when the whole window has been written.
- Sits between the capture FIFO and the H2F/F2H memory bridge.

---
 rtl/wr_ctrl.sv | 135 +++++++++++++
 tb/tb_wr_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ctrl.sv
// Avalon-MM burst write master: drains a show-ahead FIFO into the window
// [dst_begin, dst_end) as bursts of at most MAX_BURST words, then pulses wr_ctrl_rdy.
module wr_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int USEDW_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_begin,
    input  logic [ADDR_W-1:0] dst_end,
    input  logic [DATA_W-1:0] fifo_out,
    input  logic              fifo_empty,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic              rd_from_fifo,
    output logic              busy,
    output logic              wr_ctrl_rdy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              write,
    output logic [15:0]       burstcount,
    input  logic              waitrequest
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DATA = 2'd1;
    localparam logic [1:0] BURST     = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] words_rem_q, words_rem_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [15:0]       burstcount_q, burstcount_d;
    logic [15:0]       beats_left_q, beats_left_d;
    logic              write_q, write_d;
    logic              rdy_q, rdy_d;

    logic              beat_ok;
    logic [15:0]       len;

    always_comb begin
        beat_ok      = write_q && !waitrequest;
        len          = (words_rem_q < ADDR_W'(MAX_BURST)) ? words_rem_q[15:0] : 16'(MAX_BURST);

        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        words_rem_d  = words_rem_q;
        address_d    = address_q;
        burstcount_d = burstcount_q;
        beats_left_d = beats_left_q;
        write_d      = write_q;
        rdy_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = {dst_begin[ADDR_W-1:2], 2'b00};
                    words_rem_d = (dst_end > dst_begin) ? (dst_end >> 2) - (dst_begin >> 2) : '0;
                    state_d     = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (words_rem_q == '0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end else if (16'(fifo_usedw) >= len) begin
                    // Only launch once the FIFO holds the whole burst, so beats never stall on data.
                    address_d    = cur_addr_q;
                    burstcount_d = len;
                    beats_left_d = len;
                    write_d      = 1'b1;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (beat_ok) begin
                    beats_left_d = beats_left_q - 16'd1;
                    if (beats_left_q == 16'd1) begin
                        write_d     = 1'b0;
                        words_rem_d = words_rem_q - ADDR_W'(burstcount_q);
                        cur_addr_d  = cur_addr_q + (ADDR_W'(burstcount_q) << 2);
                        state_d     = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            words_rem_q  <= '0;
            address_q    <= '0;
            burstcount_q <= '0;
            beats_left_q <= '0;
            write_q      <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            words_rem_q  <= words_rem_d;
            address_q    <= address_d;
            burstcount_q <= burstcount_d;
            beats_left_q <= beats_left_d;
            write_q      <= write_d;
            rdy_q        <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(rd_from_fifo && fifo_empty));
            assert (!write_q || (burstcount_q != '0));
        end
    end

    assign rd_from_fifo = beat_ok;
    assign writedata    = fifo_out;
    assign busy         = (state_q != IDLE);
    assign wr_ctrl_rdy  = rdy_q;
    assign address      = address_q;
    assign write        = write_q;
    assign burstcount   = burstcount_q;

endmodule

// File: tb/tb_wr_ctrl.sv
// Directed bench for wr_ctrl: a counting FIFO model feeds the DUT and a
// posedge monitor records accepted beats into a word-addressed memory.
module tb_wr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_begin = '0;
    logic [31:0] dst_end = '0;
    logic [31:0] fifo_out;
    logic        fifo_empty;
    logic [8:0]  fifo_usedw;
    logic        rd_from_fifo;
    logic        busy;
    logic        wr_ctrl_rdy;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        write;
    logic [15:0] burstcount;
    logic        waitrequest = 1'b0;

    int unsigned fill_total = 0;
    int unsigned pop_total = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] blog_addr [0:63];
    logic [15:0] blog_len [0:63];
    int          blog_n = 0;
    int          rdy_cnt = 0;
    int          beat = 0;
    logic        write_prev = 1'b0;

    wr_ctrl #(
        .DATA_W(32),
        .ADDR_W(32),
        .MAX_BURST(16),
        .USEDW_W(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dst_begin(dst_begin),
        .dst_end(dst_end),
        .fifo_out(fifo_out),
        .fifo_empty(fifo_empty),
        .fifo_usedw(fifo_usedw),
        .rd_from_fifo(rd_from_fifo),
        .busy(busy),
        .wr_ctrl_rdy(wr_ctrl_rdy),
        .address(address),
        .writedata(writedata),
        .write(write),
        .burstcount(burstcount),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int unsigned k);
        return 32'hA500_0000 + k;
    endfunction

    assign fifo_out   = word(pop_total);
    assign fifo_usedw = 9'(fill_total - pop_total);
    assign fifo_empty = (fill_total == pop_total);

    always @(posedge clk) begin
        if (write === 1'b1 && waitrequest === 1'b0) begin
            mem[12'((address >> 2) + 32'(beat))] <= writedata;
            beat <= beat + 1;
        end else if (write !== 1'b1) begin
            beat <= 0;
        end
        if (rd_from_fifo === 1'b1)
            pop_total <= pop_total + 1;
        if (write === 1'b1 && write_prev !== 1'b1 && blog_n < 64) begin
            blog_addr[blog_n] <= address;
            blog_len[blog_n]  <= burstcount;
            blog_n <= blog_n + 1;
        end
        write_prev <= write;
        if (wr_ctrl_rdy === 1'b1)
            rdy_cnt <= rdy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem[a[13:2]];
    endfunction

    task automatic do_start(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        dst_begin = b;
        dst_end   = e;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_write(input int max);
        int n = 0;
        while (write !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq("write_timeout", 64'(write), 64'd1);
    endtask

    initial begin
        int unsigned p0;
        int          b0;
        int          r0;
        logic        saw_write;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_write", 64'(write), 64'd0);
        check_eq("rst_addr", 64'(address), 64'd0);
        check_eq("rst_bc", 64'(burstcount), 64'd0);
        check_eq("rst_rdy", 64'(wr_ctrl_rdy), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two bursts: 16 + 4 words, no stalls
        fill_total = fill_total + 20;
        p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
        do_start(32'h1000, 32'h1050);
        check_eq("t1_busy", 64'(busy), 64'd1);
        check_eq("t1_wr_lat0", 64'(write), 64'd0);
        @(negedge clk);
        check_eq("t1_wr_lat1", 64'(write), 64'd1);
        check_eq("t1_addr", 64'(address), 64'h1000);
        check_eq("t1_bc", 64'(burstcount), 64'd16);
        wait_idle(200);
        check_eq("t1_pops", 64'(pop_total - p0), 64'd20);
        check_eq("t1_nburst", 64'(blog_n - b0), 64'd2);
        check_eq("t1_b0addr", 64'(blog_addr[b0]), 64'h1000);
        check_eq("t1_b0len", 64'(blog_len[b0]), 64'd16);
        check_eq("t1_b1addr", 64'(blog_addr[b0+1]), 64'h1040);
        check_eq("t1_b1len", 64'(blog_len[b0+1]), 64'd4);
        check_eq("t1_rdy", 64'(rdy_cnt - r0), 64'd1);
        check_eq("t1_m1000", 64'(mem_rd(32'h1000)), 64'(word(p0)));
        check_eq("t1_m103c", 64'(mem_rd(32'h103C)), 64'(word(p0 + 15)));
        check_eq("t1_m1040", 64'(mem_rd(32'h1040)), 64'(word(p0 + 16)));
        check_eq("t1_m104c", 64'(mem_rd(32'h104C)), 64'(word(p0 + 19)));

        // Same window with a 3-cycle stall on the third beat
        fill_total = fill_total + 20;
        p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
        do_start(32'h1000, 32'h1050);
        wait_write(50);
        repeat (2) @(negedge clk);
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t2_hold_wr", 64'(write), 64'd1);
            check_eq("t2_hold_addr", 64'(address), 64'h1000);
            check_eq("t2_hold_data", 64'(writedata), 64'(word(p0 + 2)));
            check_eq("t2_hold_pop", 64'(rd_from_fifo), 64'd0);
        end
        check_eq("t2_pops_stall", 64'(pop_total - p0), 64'd2);
        waitrequest = 1'b0;
        wait_idle(200);
        check_eq("t2_pops", 64'(pop_total - p0), 64'd20);
        check_eq("t2_nburst", 64'(blog_n - b0), 64'd2);
        check_eq("t2_rdy", 64'(rdy_cnt - r0), 64'd1);
        check_eq("t2_m1008", 64'(mem_rd(32'h1008)), 64'(word(p0 + 2)));
        check_eq("t2_m100c", 64'(mem_rd(32'h100C)), 64'(word(p0 + 3)));
        check_eq("t2_m104c", 64'(mem_rd(32'h104C)), 64'(word(p0 + 19)));

        // Burst waits for fill level
        fill_total = fill_total + 3;
        p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
        do_start(32'h2000, 32'h2020);
        saw_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (write !== 1'b0) saw_write = 1'b1;
        end
        check_eq("t3_no_early_wr", 64'(saw_write), 64'd0);
        fill_total = fill_total + 5;
        @(negedge clk);
        check_eq("t3_wr", 64'(write), 64'd1);
        check_eq("t3_addr", 64'(address), 64'h2000);
        check_eq("t3_bc", 64'(burstcount), 64'd8);
        wait_idle(100);
        check_eq("t3_pops", 64'(pop_total - p0), 64'd8);
        check_eq("t3_nburst", 64'(blog_n - b0), 64'd1);
        check_eq("t3_rdy", 64'(rdy_cnt - r0), 64'd1);
        check_eq("t3_m201c", 64'(mem_rd(32'h201C)), 64'(word(p0 + 7)));

        // Reset on beat 5 of a 16-beat burst, then a clean rerun
        fill_total = fill_total + 16;
        p0 = pop_total; r0 = rdy_cnt;
        do_start(32'h1000, 32'h1040);
        wait_write(50);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_wr", 64'(write), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_addr", 64'(address), 64'd0);
        check_eq("t5_bc", 64'(burstcount), 64'd0);
        check_eq("t5_rdy", 64'(wr_ctrl_rdy), 64'd0);
        check_eq("t5_pops", 64'(pop_total - p0), 64'd5);
        reset = 1'b1;
        fill_total = fill_total + 5;
        p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
        do_start(32'h1000, 32'h1040);
        wait_idle(200);
        check_eq("t5r_pops", 64'(pop_total - p0), 64'd16);
        check_eq("t5r_nburst", 64'(blog_n - b0), 64'd1);
        check_eq("t5r_len", 64'(blog_len[b0]), 64'd16);
        check_eq("t5r_rdy", 64'(rdy_cnt - r0), 64'd1);
        check_eq("t5r_m1000", 64'(mem_rd(32'h1000)), 64'(word(p0)));
        check_eq("t5r_m103c", 64'(mem_rd(32'h103C)), 64'(word(p0 + 15)));

        // start during BURST is ignored
        fill_total = fill_total + 20;
        p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
        do_start(32'h1000, 32'h1050);
        wait_write(50);
        dst_begin = 32'h5000;
        dst_end   = 32'h5100;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_idle(200);
        repeat (4) @(negedge clk);
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_pops", 64'(pop_total - p0), 64'd20);
        check_eq("t6_nburst", 64'(blog_n - b0), 64'd2);
        check_eq("t6_rdy", 64'(rdy_cnt - r0), 64'd1);

        // Empty and inverted windows: completion after two cycles, no traffic
        fill_total = fill_total + 4;
        for (int k = 0; k < 2; k++) begin
            p0 = pop_total; b0 = blog_n; r0 = rdy_cnt;
            do_start(32'h3000, (k == 0) ? 32'h3000 : 32'h2000);
            check_eq("t7_busy", 64'(busy), 64'd1);
            check_eq("t7_rdy_early", 64'(wr_ctrl_rdy), 64'd0);
            @(negedge clk);
            check_eq("t7_rdy", 64'(wr_ctrl_rdy), 64'd1);
            @(negedge clk);
            check_eq("t7_rdy_off", 64'(wr_ctrl_rdy), 64'd0);
            check_eq("t7_idle", 64'(busy), 64'd0);
            check_eq("t7_pops", 64'(pop_total - p0), 64'd0);
            check_eq("t7_nburst", 64'(blog_n - b0), 64'd0);
            check_eq("t7_rdycnt", 64'(rdy_cnt - r0), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
